// File: rtl/fx2_reg_capture.sv
// fx2_reg_capture: captures register writes strobed by the Beagle over the FX2
// pin bus. All raw pins are synchronized, the write strobe is debounced by a
// qualify/commit/release FSM, and a debounced soft reset clears the bank.
module fx2_reg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] pin_bus,
    input  logic        nREGEN,
    input  logic        nRESET,
    output logic [7:0]  led,
    output logic        wr_pulse,
    output logic [7:0]  glitch_cnt,
    output logic [7:0]  parity_err_cnt
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] QUALIFY = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [21:0] bus_meta_reg;
    logic [21:0] bus_s;
    logic        regen_meta_reg;
    logic        regen_s;
    logic        rst_meta_reg;
    logic        rst_s;

    logic [3:0]  srst_cnt_reg;
    logic        soft_clear;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [3:0]  cnt_reg;
    logic [3:0]  cnt_next;
    logic        glitch_event;
    logic        parity_ok;
    logic        in_commit;
    logic        parity_event;

    logic [7:0]  glitch_reg;
    logic [7:0]  perr_reg;
    logic [7:0]  bank [8];

    // Bus bits [21:12] are carried through the synchronizer but have no meaning.
    logic        unused_bus;
    assign unused_bus = ^bus_s[21:12];

    // Two-flop synchronizers; strobes idle high, the data bus idles low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_meta_reg   <= '0;
            bus_s          <= '0;
            regen_meta_reg <= 1'b1;
            regen_s        <= 1'b1;
            rst_meta_reg   <= 1'b1;
            rst_s          <= 1'b1;
        end else begin
            bus_meta_reg   <= pin_bus;
            bus_s          <= bus_meta_reg;
            regen_meta_reg <= nREGEN;
            regen_s        <= regen_meta_reg;
            rst_meta_reg   <= nRESET;
            rst_s          <= rst_meta_reg;
        end
    end

    // Soft reset qualifier: counts consecutive low samples, saturating once qualified
    // so the clear stays asserted for as long as nRESET is held low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srst_cnt_reg <= '0;
        end else if (!rst_s) begin
            if (srst_cnt_reg != STABLE_N) begin
                srst_cnt_reg <= srst_cnt_reg + 4'd1;
            end
        end else begin
            srst_cnt_reg <= '0;
        end
    end

    assign soft_clear = (srst_cnt_reg == STABLE_N);

    // Commit decision: even parity across address, data and parity bit.
    assign parity_ok    = ~^bus_s[11:0];
    assign in_commit    = (state_reg == COMMIT);
    assign wr_pulse     = in_commit && parity_ok && !soft_clear;
    assign parity_event = in_commit && !parity_ok && !soft_clear;

    // Strobe FSM next state; cnt_reg is the low count in QUALIFY and the high count in RELEASE.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        glitch_event = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!regen_s) begin
                    state_next = QUALIFY;
                    cnt_next   = 4'd1;
                end
            end
            QUALIFY: begin
                if (cnt_reg == STABLE_N) begin
                    state_next = COMMIT;
                    cnt_next   = '0;
                end else if (regen_s) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    glitch_event = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            COMMIT: begin
                state_next = RELEASE;
                cnt_next   = '0;
            end
            RELEASE: begin
                if (regen_s) begin
                    if (cnt_reg == STABLE_N - 4'd1) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state register; the soft clear overrides any transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (soft_clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Saturating error counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_reg <= '0;
            perr_reg   <= '0;
        end else if (soft_clear) begin
            glitch_reg <= '0;
            perr_reg   <= '0;
        end else begin
            if (glitch_event && glitch_reg != 8'hFF) begin
                glitch_reg <= glitch_reg + 8'd1;
            end
            if (parity_event && perr_reg != 8'hFF) begin
                perr_reg <= perr_reg + 8'd1;
            end
        end
    end

    assign glitch_cnt     = glitch_reg;
    assign parity_err_cnt = perr_reg;

    // Register bank: each register loads on a committed write addressed to it.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [7:0] value_reg;

            // One bank register with hard and soft clear.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (soft_clear) begin
                    value_reg <= '0;
                end else if (wr_pulse && bus_s[10:8] == 3'(gi)) begin
                    value_reg <= bus_s[7:0];
                end
            end

            assign bank[gi] = value_reg;
        end
    endgenerate

    // reg7[2:0] picks the register shown on the LEDs.
    assign led = bank[bank[7][2:0]];

endmodule

// File: tb/tb_fx2_reg_capture.sv
// Directed testbench for fx2_reg_capture (STABLE_CYCLES = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fx2_reg_capture;

    logic        clk;
    logic        reset;
    logic [21:0] pin_bus;
    logic        nREGEN;
    logic        nRESET;
    logic [7:0]  led;
    logic        wr_pulse;
    logic [7:0]  glitch_cnt;
    logic [7:0]  parity_err_cnt;

    int n_total;
    int n_pass;

    fx2_reg_capture #(.STABLE_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pin_bus        (pin_bus),
        .nREGEN         (nREGEN),
        .nRESET         (nRESET),
        .led            (led),
        .wr_pulse       (wr_pulse),
        .glitch_cnt     (glitch_cnt),
        .parity_err_cnt (parity_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the bus with the given address/data; upper pins carry junk.
    task automatic set_bus(input logic [2:0] addr, input logic [7:0] data, input bit bad_par);
        logic par;
        par     = (^{addr, data}) ^ bad_par;
        pin_bus = {10'h3FF, par, addr, data};
    endtask

    // One strobe: nREGEN low for low_cycles negedges, then high for 10 more.
    task automatic strobe(input logic [2:0] addr, input logic [7:0] data, input bit bad_par,
                          input int low_cycles, output int pulses, output int first_edge,
                          output logic [7:0] led_at, output logic [7:0] led_after);
        pulses     = 0;
        first_edge = 0;
        led_at     = 8'h00;
        led_after  = 8'h00;
        set_bus(addr, data, bad_par);
        nREGEN = 1'b0;
        for (int k = 1; k <= low_cycles + 10; k++) begin
            @(negedge clk);
            if (first_edge != 0 && k == first_edge + 1) led_after = led;
            if (wr_pulse) begin
                pulses++;
                if (first_edge == 0) begin
                    first_edge = k;
                    led_at     = led;
                end
            end
            if (k == low_cycles) nREGEN = 1'b1;
        end
        $display("strobe addr=%0d data=0x%02h badpar=%0d low=%0d pulses=%0d edge=%0d led=0x%02h",
                 addr, data, bad_par, low_cycles, pulses, first_edge, led);
    endtask

    int         pulses;
    int         fe;
    logic [7:0] l_at;
    logic [7:0] l_after;

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        nREGEN  = 1'b1;
        nRESET  = 1'b1;
        pin_bus = '0;
        repeat (3) @(negedge clk);
        check_val("rst_led", led, 8'h00);
        check_val("rst_wr_pulse", wr_pulse, 1'b0);
        check_val("rst_glitch", glitch_cnt, 8'h00);
        check_val("rst_perr", parity_err_cnt, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic write of 0xA5 to reg0 with nREGEN low for 10 cycles.
        strobe(3'd0, 8'hA5, 1'b0, 10, pulses, fe, l_at, l_after);
        check_val("w0_pulses", pulses, 1);
        check_val("w0_edge", fe, 7);
        check_val("w0_led_at_pulse", l_at, 8'h00);
        check_val("w0_led_after", l_after, 8'hA5);
        check_val("w0_glitch", glitch_cnt, 8'h00);
        check_val("w0_perr", parity_err_cnt, 8'h00);

        // Two-cycle glitch: rejected.
        strobe(3'd1, 8'h77, 1'b0, 2, pulses, fe, l_at, l_after);
        check_val("gl_pulses", pulses, 0);
        check_val("gl_glitch", glitch_cnt, 8'h01);
        check_val("gl_led", led, 8'hA5);

        // Parity error on a write to reg2.
        strobe(3'd2, 8'h3C, 1'b1, 10, pulses, fe, l_at, l_after);
        check_val("pe_pulses", pulses, 0);
        check_val("pe_perr", parity_err_cnt, 8'h01);
        strobe(3'd7, 8'h02, 1'b0, 10, pulses, fe, l_at, l_after);
        check_val("pe_sel_pulses", pulses, 1);
        check_val("pe_reg2_zero", led, 8'h00);
        strobe(3'd7, 8'h00, 1'b0, 10, pulses, fe, l_at, l_after);
        check_val("pe_sel0_led", led, 8'hA5);

        // Long strobes: exactly one pulse each; LED selects reg2 a cycle after the pulse.
        strobe(3'd2, 8'h3C, 1'b0, 50, pulses, fe, l_at, l_after);
        check_val("long1_pulses", pulses, 1);
        check_val("long1_led", led, 8'hA5);
        strobe(3'd7, 8'h02, 1'b0, 50, pulses, fe, l_at, l_after);
        check_val("long2_pulses", pulses, 1);
        check_val("long2_led_at", l_at, 8'hA5);
        check_val("long2_led_after", l_after, 8'h3C);

        // 300 glitches saturate the glitch counter.
        for (int i = 0; i < 300; i++) begin
            nREGEN = 1'b0;
            repeat (2) @(negedge clk);
            nREGEN = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_val("sat_glitch", glitch_cnt, 8'hFF);
        check_val("sat_led", led, 8'h3C);

        // Soft reset: nRESET low for 4 cycles.
        nRESET = 1'b0;
        repeat (4) @(negedge clk);
        nRESET = 1'b1;
        repeat (6) @(negedge clk);
        $display("soft reset glitch=%0d perr=%0d led=0x%02h", glitch_cnt, parity_err_cnt, led);
        check_val("sr_glitch", glitch_cnt, 8'h00);
        check_val("sr_perr", parity_err_cnt, 8'h00);
        check_val("sr_led", led, 8'h00);
        strobe(3'd7, 8'h02, 1'b0, 10, pulses, fe, l_at, l_after);
        check_val("sr_reg2_zero", led, 8'h00);
        strobe(3'd2, 8'h3C, 1'b0, 10, pulses, fe, l_at, l_after);
        check_val("pre_clr_led", led, 8'h3C);

        // Soft reset qualifies in the same cycle as COMMIT: the write is discarded.
        pulses = 0;
        set_bus(3'd2, 8'h99, 1'b0);
        nREGEN = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wr_pulse) pulses++;
            if (k == 1) nRESET = 1'b0;
            if (k == 4) nREGEN = 1'b1;
            if (k == 5) nRESET = 1'b1;
        end
        $display("commit+soft reset pulses=%0d led=0x%02h", pulses, led);
        check_val("clr_commit_pulses", pulses, 0);
        check_val("clr_commit_led", led, 8'h00);
        strobe(3'd7, 8'h02, 1'b0, 10, pulses, fe, l_at, l_after);
        check_val("clr_commit_reg2", led, 8'h00);

        // Hard reset in QUALIFY aborts; a still-low nREGEN starts a new strobe.
        set_bus(3'd0, 8'h5A, 1'b0);
        nREGEN = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("hr_wr_pulse", wr_pulse, 1'b0);
        check_val("hr_led", led, 8'h00);
        reset = 1'b0;
        pulses = 0;
        fe     = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (wr_pulse) begin
                pulses++;
                if (fe == 0) fe = k;
            end
        end
        nREGEN = 1'b1;
        repeat (10) @(negedge clk);
        $display("reset mid-strobe pulses=%0d edge=%0d led=0x%02h", pulses, fe, led);
        check_val("hr_pulses", pulses, 1);
        check_val("hr_edge", fe, 7);
        check_val("hr_led_after", led, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
